// File: rtl/bsg_round_robin_dispatch_if.sv
// ============================================================================
// bsg_round_robin_dispatch_if: input stream plus els_p-way dispatch bus for bsg_round_robin_dispatch
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bsg_round_robin_dispatch_if #(
   parameter int width_p = 32,
   parameter int els_p   = 4
);
   localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic                    v_i;
   logic [width_p-1:0]      data_i;
   logic                    ready_o;
   logic [els_p-1:0]        v_o;
   logic [width_p-1:0]      data_o;
   logic [tag_width_lp-1:0] tag_o;
   logic [els_p-1:0]        ready_i;

   // The dispatcher itself is the slave of this bus.
   modport slave (
      input  v_i,
      input  data_i,
      output ready_o,
      output v_o,
      output data_o,
      output tag_o,
      input  ready_i
   );

   modport master (
      output v_i,
      output data_i,
      input  ready_o,
      input  v_o,
      input  data_o,
      input  tag_o,
      output ready_i
   );
endinterface

`default_nettype wire

// File: rtl/bsg_round_robin_dispatch.sv
// ============================================================================
// bsg_round_robin_dispatch: one-entry slot dispatched round-robin to els_p consumers;
// define BSG_RR_DISPATCH_STRICT_EN for strict rotation. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bsg_round_robin_dispatch #(
   parameter int width_p = 32,
   parameter int els_p   = 4,
   localparam int tag_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   bsg_round_robin_dispatch_if.slave    io
);

   logic                    full_q, full_d;
   logic [width_p-1:0]      data_q;
   logic [tag_width_lp-1:0] ptr_q, ptr_d;

   logic [tag_width_lp-1:0] sel;
   logic                    sel_v;
   logic [els_p-1:0]        v_onehot;
   logic                    dispatch;
   logic                    in_xfer;
   logic                    ready;

`ifdef BSG_RR_DISPATCH_STRICT_EN
   // Strict rotation: the favoured channel is the only candidate.
   always_comb begin
      sel   = ptr_q;
      sel_v = 1'b1;
   end
`else
   logic                    hi_v, lo_v;
   logic [tag_width_lp-1:0] hi_sel, lo_sel;

   // Lowest ready channel at or above ptr_q wins; otherwise wrap to the lowest ready channel.
   always_comb begin
      hi_v   = 1'b0;
      hi_sel = '0;
      lo_v   = 1'b0;
      lo_sel = '0;
      for (int k = els_p - 1; k >= 0; k--) begin
         if (io.ready_i[k]) begin
            lo_v   = 1'b1;
            lo_sel = tag_width_lp'(k);
            if (tag_width_lp'(k) >= ptr_q) begin
               hi_v   = 1'b1;
               hi_sel = tag_width_lp'(k);
            end
         end
      end
      sel_v = hi_v | lo_v;
      sel   = hi_v ? hi_sel : lo_sel;
   end
`endif

   for (genvar k = 0; k < els_p; k++) begin : g_onehot
      assign v_onehot[k] = full_q & sel_v & (sel == tag_width_lp'(k));
   end

   assign dispatch = |(v_onehot & io.ready_i);
   assign ready    = ~full_q | dispatch;
   assign in_xfer  = io.v_i & ready;

   always_comb begin
      full_d = full_q;
      ptr_d  = ptr_q;
      if (in_xfer) begin
         full_d = 1'b1;
      end else if (dispatch) begin
         full_d = 1'b0;
      end
      if (dispatch) begin
         ptr_d = (sel == tag_width_lp'(els_p - 1)) ? '0 : sel + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         full_q <= 1'b0;
         ptr_q  <= '0;
      end else begin
         full_q <= full_d;
         ptr_q  <= ptr_d;
      end
   end

   // Payload needs no reset: it is only observed while full_q is set.
   always_ff @(posedge clk_i) begin
      if (reset_i && in_xfer) begin
         data_q <= io.data_i;
      end
   end

   assign io.ready_o = ready;
   assign io.v_o     = v_onehot;
   assign io.data_o  = data_q;
   assign io.tag_o   = (|v_onehot) ? sel : '0;

endmodule

`default_nettype wire

// File: tb/tb_bsg_round_robin_dispatch.sv
// ============================================================================
// tb_bsg_round_robin_dispatch: scoreboard bench for a 4-channel and a 1-channel dispatcher
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bsg_round_robin_dispatch;
   localparam int W = 32;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset_i = 1'b0;
   always #5 clk = ~clk;

   bsg_round_robin_dispatch_if #(.width_p(W), .els_p(N)) bus0 ();
   bsg_round_robin_dispatch_if #(.width_p(W), .els_p(1)) bus1 ();

   bsg_round_robin_dispatch #(.width_p(W), .els_p(N)) dut0 (
      .clk_i(clk), .reset_i(reset_i), .io(bus0)
   );
   bsg_round_robin_dispatch #(.width_p(W), .els_p(1)) dut1 (
      .clk_i(clk), .reset_i(reset_i), .io(bus1)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   int  mptr = 0;
   int  disp_cnt = 0;
   int  d1_cnt = 0;
   int  last_tag = -1;
   bit  acc0 = 0, acc1 = 0;
   logic [W-1:0] accd0 = '0, accd1 = '0;
   bit  main_done = 0, done1 = 0;

   initial begin
      bus0.v_i = 1'b0; bus0.data_i = '0; bus0.ready_i = '0;
      bus1.v_i = 1'b0; bus1.data_i = '0; bus1.ready_i = '0;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference choice of channel from the rules: scan cyclically from the favoured channel.
   function automatic int model_sel(input int p, input logic [N-1:0] r);
`ifdef BSG_RR_DISPATCH_STRICT_EN
      model_sel = p;
`else
      model_sel = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (r[(p + i) % N] === 1'b1) model_sel = (p + i) % N;
      end
`endif
   endfunction

   // Monitor for the 4-channel instance.
   always @(negedge clk) begin
      logic [N-1:0] r;
      logic [N-1:0] ev;
      int  s;
      bit  full, ed;
      if (reset_i !== 1'b1) begin
         q0.delete();
         mptr = 0;
      end else begin
         r    = bus0.ready_i;
         full = (q0.size() != 0);
         s    = model_sel(mptr, r);
         ev   = '0;
         if (full && s >= 0) ev[s] = 1'b1;
         ed   = |(ev & r);
         chk("v_o", bus0.v_o, ev);
         chk("tag_o", bus0.tag_o, (ev != 0) ? s : 0);
         chk("ready_o", bus0.ready_o, (!full || ed) ? 1 : 0);
         if (full) chk("data_o", bus0.data_o, q0[0]);
         if (|(bus0.v_o & r)) begin
            disp_cnt++;
            last_tag = int'(bus0.tag_o);
         end
         if (ed) begin
            void'(q0.pop_front());
            mptr = (s + 1) % N;
         end
      end
   end

   // Monitor for the single-channel instance.
   always @(negedge clk) begin
      bit full, ev, ed;
      if (reset_i !== 1'b1) begin
         q1.delete();
      end else begin
         full = (q1.size() != 0);
`ifdef BSG_RR_DISPATCH_STRICT_EN
         ev = full;
`else
         ev = full && (bus1.ready_i[0] === 1'b1);
`endif
         ed = ev && (bus1.ready_i[0] === 1'b1);
         chk("v_o_1ch", bus1.v_o, ev);
         chk("tag_o_1ch", bus1.tag_o, 0);
         chk("ready_o_1ch", bus1.ready_o, (!full || ed) ? 1 : 0);
         if (full) chk("data_o_1ch", bus1.data_o, q1[0]);
         if (bus1.v_o[0] === 1'b1 && bus1.ready_i[0] === 1'b1) d1_cnt++;
         if (ed) void'(q1.pop_front());
      end
   end

   // One cycle of stimulus on the 4-channel instance; accepted words enter the scoreboard.
   task automatic cyc0(input bit rst, input bit v, input logic [W-1:0] d, input logic [N-1:0] r);
      @(posedge clk);
      #1;
      if (acc0) q0.push_back(accd0);
      reset_i      = ~rst;
      bus0.v_i     = v;
      bus0.data_i  = d;
      bus0.ready_i = r;
      @(negedge clk);
      acc0  = v && (bus0.ready_o === 1'b1) && !rst;
      accd0 = d;
   endtask

   task automatic cyc1(input bit v, input logic [W-1:0] d, input logic r);
      @(posedge clk);
      #1;
      if (acc1) q1.push_back(accd1);
      bus1.v_i        = v;
      bus1.data_i     = d;
      bus1.ready_i[0] = r;
      @(negedge clk);
      acc1  = v && (bus1.ready_o === 1'b1) && (reset_i === 1'b1);
      accd1 = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Single-channel stream: in-order delivery under a toggling consumer.
   initial begin
      logic [3:0] pat;
      int w, ph, base;
      pat = 4'b1101;
      wait (reset_i === 1'b1);
      base = d1_cnt;
      w = 1;
      ph = 0;
      while (w <= 4 && ph < 40) begin
         cyc1(1'b1, W'(w), pat[ph % 4]);
         if (acc1) w++;
         ph++;
      end
      repeat (3) cyc1(1'b0, '0, 1'b1);
      chk("one_ch_delivered", d1_cnt - base, 4);
      while (!main_done) cyc1($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
      repeat (5) cyc1(1'b0, '0, 1'b1);
      done1 = 1;
   end

   initial begin
      int base;
      // Reset and idle.
      cyc0(1'b1, 1'b0, '0, '0);
      cyc0(1'b1, 1'b0, '0, '0);
      repeat (3) cyc0(1'b0, 1'b0, '0, N'($urandom));

      // Full-rate rotation across all channels.
      base = disp_cnt;
      for (int i = 0; i < 8; i++) cyc0(1'b0, 1'b1, W'(32'hA0 + i), 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      chk("rotation_count", disp_cnt - base, 8);

      // Favour channel 1, then offer a word with only channels 0 and 3 ready.
      cyc0(1'b0, 1'b1, 32'h11, 4'b0001);
      cyc0(1'b0, 1'b0, '0, 4'b0001);
      cyc0(1'b0, 1'b1, 32'h55, 4'b1001);
      cyc0(1'b0, 1'b0, '0, 4'b1001);
      cyc0(1'b0, 1'b0, '0, 4'b1001);
`ifdef BSG_RR_DISPATCH_STRICT_EN
      chk("strict_wait_v", bus0.v_o, 4'b0010);
      chk("strict_wait_ready", bus0.ready_o, 0);
      cyc0(1'b0, 1'b0, '0, 4'b0010);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      chk("strict_release_tag", last_tag, 1);
`else
      chk("skip_busy_tag", last_tag, 3);
`endif

      // Back-pressure with every consumer stalled.
      cyc0(1'b0, 1'b1, 32'h77, 4'b0000);
      repeat (5) cyc0(1'b0, 1'b1, 32'hDEAD, 4'b0000);
      chk("bp_data", bus0.data_o, 32'h77);
      chk("bp_ready", bus0.ready_o, 0);
      cyc0(1'b0, 1'b0, '0, 4'b0100);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      chk("bp_release_tag", last_tag, 2);

      // Steer the pointer to 2, park 0x33, then reset.
      for (int i = 0; i < 3; i++) cyc0(1'b0, 1'b1, W'(32'hB0 + i), 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      cyc0(1'b0, 1'b1, 32'h33, 4'b0000);
      cyc0(1'b0, 1'b0, '0, 4'b0000);
      cyc0(1'b1, 1'b0, '0, 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      chk("post_reset_v", bus0.v_o, 0);
      chk("post_reset_ready", bus0.ready_o, 1);
      cyc0(1'b0, 1'b1, 32'h44, 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      cyc0(1'b0, 1'b0, '0, 4'hF);
      chk("post_reset_ptr", last_tag, 0);

      // Randomised traffic with occasional resets.
      repeat (3000) begin
         cyc0($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom,
              ($urandom_range(0, 7) == 0) ? 4'h0 : N'($urandom));
      end
      repeat (6) cyc0(1'b0, 1'b0, '0, 4'hF);
      main_done = 1;
      for (int i = 0; i < 200 && !done1; i++) @(posedge clk);
      chk("one_ch_finish", done1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
